fifo_stream_reader: RTL
=======================

# fifo_stream_reader

Read-side consumer for the asynchronous FIFO, running entirely in the read clock domain. It pops words from the FIFO's show-ahead read port and presents them as a valid/ready stream with no combinational path from `out_ready` to the FIFO. It groups words into fixed-length frames marked by `out_last`, and keeps running word and frame counters for debug.

## Interface
Parameters:
- `WIDTH`, 8, data word width; must match the FIFO.
- `BURST_LEN`, 4, words per frame; legal range 1..256.
- `CNT_WIDTH`, 16, width of the statistics counters.

Ports:
- `rd_clk`  in  1  the only clock (FIFO read clock).
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  allows new FIFO pops when high.
- `fifo_rd_empty`  in  1  FIFO empty flag, already synchronous to `rd_clk`.
- `fifo_rd_data`  in  WIDTH  FIFO head word; valid whenever `fifo_rd_empty`=0.
- `fifo_rd_en`  out  1  pop strobe; the FIFO advances at the edge where this is 1.
- `out_data`  out  WIDTH  stream data.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready from the downstream sink.
- `out_last`  out  1  marks the final word of a frame.
- `word_count`  out  CNT_WIDTH  count of accepted output words.
- `frame_count`  out  CNT_WIDTH  count of accepted `out_last` words.

## Operation
- Internal 2-entry buffer with registered occupancy `occ` in {0,1,2}.
- Pop rule: `fifo_rd_en` = `enable` & !`fifo_rd_empty` & (`occ` != 2). This is the only logic driving `fifo_rd_en`.
- On a pop edge, `fifo_rd_data` is written into the buffer tail.
- An output handshake occurs when `out_valid` & `out_ready`. It removes the buffer head.
- Occupancy update: `occ` += pop − handshake. A pop and a handshake in the same cycle leave `occ` unchanged.
- `out_valid` = (`occ` != 0).
- `out_data` is the head entry. While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` are held stable.
- Framing FSM:
  - States: IDLE (beat=0, no word of the current frame accepted) and IN_FRAME (beat 1..BURST_LEN-1).
  - `out_last` = `out_valid` & (beat == BURST_LEN-1).
  - On each handshake, beat increments. It wraps to 0 and returns to IDLE on the `out_last` handshake.
  - With BURST_LEN=1, every word has `out_last`=1 and the FSM stays in IDLE.
- Counters:
  - `word_count` increments on every handshake.
  - `frame_count` increments on every handshake with `out_last`=1.
  - Both wrap modulo 2^CNT_WIDTH.
- Deasserting `enable` only stops pops. Buffered words still drain, and the frame position is kept. Frames are never truncated.

## Timing
- Reset (`reset_n`=0, asynchronous): `occ`=0, beat=0, FSM in IDLE. All outputs are 0: `fifo_rd_en`, `out_valid`, `out_last`, `out_data`, `word_count`, `frame_count`.
- `fifo_rd_en` can be 1 in the first cycle after reset release if the FIFO is non-empty.
- Latency: a word popped at edge N gives `out_valid`=1 from edge N (visible in cycle N+1).
- Throughput: with `out_ready` held high, one word per cycle in steady state, with `occ`=1.
- Backpressure:
  - `out_ready` low with `occ`=1 allows exactly one more pop, then `fifo_rd_en` drops.
  - `occ`=2 blocks pops until a handshake occurs.
- FIFO goes empty mid-stream: `fifo_rd_en`=0 that cycle. The buffer drains, and `out_valid` falls once `occ` reaches 0.
- Reset asserted mid-frame: any buffered words are discarded and counters clear. The next accepted word is beat 0.

## Structure
- Shared package `fifo_pkg`:
  - FSM state encoding (IDLE=1'b0, IN_FRAME=1'b1).
  - Default WIDTH and default CNT_WIDTH constants, shared with the async FIFO.
- Sub-module `skid_buf2`: the 2-entry buffer with `occ`, push/pop, head output and space flag. The top level holds the pop rule, the framing FSM and the counters.

## Test plan
- Reset then 8 words 0x01..0x08 preloaded, `out_ready`=1, BURST_LEN=4 → 8 consecutive beats; `out_last` on 0x04 and 0x08; `word_count`=8, `frame_count`=2.
- 3 words buffered, `out_ready`=0 → exactly 2 pops then `fifo_rd_en`=0; `out_data`=first word held stable; `out_ready`=1 → words delivered in order, no loss or duplicate.
- FIFO empty for 5 cycles mid-frame after 2 accepted words → `out_valid`=0 during the gap, beat held; the next word is beat 2 and `out_last` appears on the 4th word.
- `enable`=0 with `occ`=2 → no pops, both buffered words drain, then `out_valid`=0; re-enable → popping resumes.
- `reset_n` pulsed low asynchronously mid-frame with `occ`=2 → all outputs 0 immediately; the next frame starts at beat 0 and counters restart from 0.
- `word_count` preloaded near wrap (CNT_WIDTH=4, 17 words, BURST_LEN=1) → `word_count`=1, `frame_count`=1, `out_last` on every word.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO and its read-side stream consumer.
// Pure declarations: no logic and no latency.
package fifo_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } frame_state_e;

  localparam int FIFO_WIDTH     = 8;
  localparam int STAT_CNT_WIDTH = 16;

  // A beat counter needs at least one bit, even for single-word frames.
  function automatic int beat_width(input int burst_len);
    return (burst_len > 1) ? $clog2(burst_len) : 1;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO show-ahead read port plus the outgoing valid/ready stream.
// master = the reader; slave = the FIFO and sink it connects to.
interface fifo_stream_reader_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
);

  logic             fifo_rd_empty;
  logic [WIDTH-1:0] fifo_rd_data;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    input  fifo_rd_empty,
    input  fifo_rd_data,
    input  out_ready,
    output fifo_rd_en,
    output out_data,
    output out_valid,
    output out_last
  );

  modport slave (
    output fifo_rd_empty,
    output fifo_rd_data,
    output out_ready,
    input  fifo_rd_en,
    input  out_data,
    input  out_valid,
    input  out_last
  );

endinterface

// File: rtl/skid_buf2.sv
// Two-entry buffer: a push is visible at the head one edge later; head is held while not popped.
// Caller must not push when has_space=0 nor pop when occ=0.
module skid_buf2 #(
  parameter int WIDTH = 8
) (
  input  logic             rd_clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [1:0]       occ,
  output logic             has_space
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;

  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_dat  = mem[rd_ptr];
  assign has_space = (occ != 2'd2);

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a show-ahead FIFO into a framed valid/ready stream; a popped word is valid the next cycle.
// out_ready only reaches state registers, so backpressure stops pops once two words are buffered.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH,
  parameter int BURST_LEN = 4,
  parameter int CNT_WIDTH = STAT_CNT_WIDTH
) (
  input  logic                 rd_clk,
  input  logic                 reset_n,
  input  logic                 enable,
  fifo_stream_reader_if.master bus,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic [CNT_WIDTH-1:0] frame_count
);

  localparam int                BEAT_W    = beat_width(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic              ONE_WORD  = 1'(BURST_LEN == 1);

  logic [1:0]        occ;
  logic              has_space;
  logic              pop_en;
  logic              hs;
  logic [BEAT_W-1:0] beat;
  logic [BEAT_W-1:0] beat_inc;
  logic              at_last;
  frame_state_e      state;

  // reset_n in the term keeps the pop strobe low for the whole reset pulse.
  assign pop_en         = reset_n & enable & ~bus.fifo_rd_empty & has_space;
  assign bus.fifo_rd_en = pop_en;
  assign bus.out_valid  = (occ != 2'd0);
  assign hs             = bus.out_valid & bus.out_ready;
  assign bus.out_last   = bus.out_valid & at_last;

  skid_buf2 #(
    .WIDTH(WIDTH)
  ) u_buf (
    .rd_clk    (rd_clk),
    .reset_n   (reset_n),
    .push      (pop_en),
    .push_dat  (bus.fifo_rd_data),
    .pop       (hs),
    .head_dat  (bus.out_data),
    .occ       (occ),
    .has_space (has_space)
  );

  // In IDLE the beat is zero by definition, so the first accepted word moves to beat 1.
  assign beat_inc = (state == IDLE) ? BEAT_W'(1) : beat + BEAT_W'(1);

  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      beat    <= '0;
      at_last <= ONE_WORD;
    end else if (hs) begin
      if (at_last) begin
        state   <= IDLE;
        beat    <= '0;
        at_last <= ONE_WORD;
      end else begin
        state   <= IN_FRAME;
        beat    <= beat_inc;
        at_last <= (beat_inc == LAST_BEAT);
      end
    end
  end

  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      word_count  <= '0;
      frame_count <= '0;
    end else begin
      if (hs) begin
        word_count <= word_count + CNT_WIDTH'(1);
      end
      if (hs && at_last) begin
        frame_count <= frame_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule
